// File: rtl/iir_biquad_scheduler.sv
// Multi-channel TDF-II biquad on one shared multiplier; accept-to-out_valid 6 cycles.
// Backpressure: result held in OUT until out_ready; in_ready low whenever not IDLE.
module iir_biquad_scheduler #(
  parameter int W   = 32,
  parameter int FSW = 16,
  parameter int CHB = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHB-1:0] in_ch,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHB-1:0] out_ch,
  output logic [W-1:0]   out_data,
  input  logic           cfg_we,
  input  logic [CHB-1:0] cfg_ch,
  input  logic [2:0]     cfg_sel,
  input  logic [W-1:0]   cfg_data,
  output logic           busy
);
  localparam int NCH = 1 << CHB;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FSW;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, P4, OUT} state_t;
  state_t state;

  logic [W-1:0] b0 [NCH];
  logic [W-1:0] b1 [NCH];
  logic [W-1:0] b2 [NCH];
  logic [W-1:0] a1 [NCH];
  logic [W-1:0] a2 [NCH];
  logic [W-1:0] d0 [NCH];
  logic [W-1:0] d1 [NCH];

  logic [CHB-1:0] ch;
  logic [W-1:0]   x, y, acc;
  logic [W-1:0]   mul_a, mul_b, prod_t;
  logic [2*W-1:0] prod;

  always_comb begin
    mul_a = '0;
    mul_b = x;
    unique case (state)
      P0:      mul_a = b0[ch];
      P1:      mul_a = b1[ch];
      P2:      begin mul_a = a1[ch]; mul_b = y; end
      P3:      mul_a = b2[ch];
      P4:      begin mul_a = a2[ch]; mul_b = y; end
      default: mul_a = '0;
    endcase
  end

  // Low 2W bits of the product are sign-agnostic, so extend and multiply unsigned.
  assign prod   = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
  assign prod_t = prod[FSW +: W];

  assign in_ready = (state == IDLE) && !cfg_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      busy      <= 1'b0;
      ch        <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      for (int i = 0; i < NCH; i++) begin
        b0[i] <= ONE;
        b1[i] <= '0;
        b2[i] <= '0;
        a1[i] <= '0;
        a2[i] <= '0;
        d0[i] <= '0;
        d1[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            case (cfg_sel)
              3'd0: b0[cfg_ch] <= cfg_data;
              3'd1: b1[cfg_ch] <= cfg_data;
              3'd2: b2[cfg_ch] <= cfg_data;
              3'd3: a1[cfg_ch] <= cfg_data;
              3'd4: a2[cfg_ch] <= cfg_data;
              3'd5: begin d0[cfg_ch] <= '0; d1[cfg_ch] <= '0; end
              default: ;
            endcase
          end else if (in_valid) begin
            ch    <= in_ch;
            x     <= in_data;
            busy  <= 1'b1;
            state <= P0;
          end
        end
        P0: begin
          y     <= prod_t + d0[ch];
          state <= P1;
        end
        P1: begin
          acc   <= prod_t + d1[ch];
          state <= P2;
        end
        P2: begin
          acc   <= acc - prod_t;
          state <= P3;
        end
        P3: begin
          d0[ch] <= acc;
          acc    <= prod_t;
          state  <= P4;
        end
        P4: begin
          d1[ch]    <= acc - prod_t;
          out_valid <= 1'b1;
          out_data  <= y;
          out_ch    <= ch;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Scoreboard bench for iir_biquad_scheduler: directed scenarios plus randomized traffic.
module tb_iir_biquad_scheduler;
  localparam int W = 32, FSW = 16, CHB = 2, NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHB-1:0] in_ch = '0;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CHB-1:0] out_ch;
  logic [W-1:0]   out_data;
  logic           cfg_we = 1'b0;
  logic [CHB-1:0] cfg_ch = '0;
  logic [2:0]     cfg_sel = '0;
  logic [W-1:0]   cfg_data = '0;
  logic           busy;

  iir_biquad_scheduler #(.W(W), .FSW(FSW), .CHB(CHB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: per-channel coefficients and delay state, fixed-point by plain arithmetic.
  logic [31:0] m_b0[NCH], m_b1[NCH], m_b2[NCH], m_a1[NCH], m_a2[NCH], m_d0[NCH], m_d1[NCH];

  function automatic logic [31:0] qmul(input logic [31:0] c, input logic [31:0] v);
    longint p;
    p = longint'($signed(c)) * longint'($signed(v));
    return 32'(p >>> FSW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_b0[i] = 32'h0001_0000;
      m_b1[i] = '0; m_b2[i] = '0; m_a1[i] = '0; m_a2[i] = '0;
      m_d0[i] = '0; m_d1[i] = '0;
    end
  endtask

  task automatic model_cfg(input int ch, input int sel, input logic [31:0] d);
    case (sel)
      0: m_b0[ch] = d;
      1: m_b1[ch] = d;
      2: m_b2[ch] = d;
      3: m_a1[ch] = d;
      4: m_a2[ch] = d;
      5: begin m_d0[ch] = '0; m_d1[ch] = '0; end
      default: ;
    endcase
  endtask

  task automatic model_sample(input int ch, input logic [31:0] xv, output logic [31:0] yv);
    yv = qmul(m_b0[ch], xv) + m_d0[ch];
    m_d0[ch] = qmul(m_b1[ch], xv) - qmul(m_a1[ch], yv) + m_d1[ch];
    m_d1[ch] = qmul(m_b2[ch], xv) - qmul(m_a2[ch], yv);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] dat;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // Monitor: latency on out_valid rise, hold stability under backpressure, data on transfer.
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;
  logic [1:0]  pc = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (busy) check("in_ready_while_busy", in_ready, 0);
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_ch", out_ch, pc);
      end
      if (out_valid && !pv) begin
        if (sbq.size() != 0) check("latency", cyc - sbq[0].cyc, 6);
        else check("spurious_out_valid", out_valid, 0);
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("out_ch", out_ch, e.ch);
        check("out_data", out_data, e.dat);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_ch;
    end
  end

  task automatic send(input int ch, input logic [31:0] xv);
    exp_t e;
    int n = 0;
    in_valid = 1'b1; in_ch = 2'(ch); in_data = xv;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.ch = ch;
    model_sample(ch, xv, e.dat);
    e.cyc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic [31:0] d);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk); n++;
    end
    if (busy) check("cfg_wait_timeout", busy, 0);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 3'(sel); cfg_data = d;
    model_cfg(ch, sel, d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 500) begin
      @(negedge clk); n++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_ch"}, out_ch, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");

    // Pass-through after reset.
    send(2, 32'h0001_2345);
    drain();

    // Impulse response with a1 = -0.5.
    cfg_write(0, 3, 32'hFFFF_8000);
    send(0, 32'd65536); send(0, 32'd0); send(0, 32'd0);
    drain();

    // Channel isolation.
    cfg_write(1, 3, 32'hFFFF_8000);
    send(1, 32'd65536); send(3, 32'd100); send(1, 32'd0); send(3, 32'd0);
    drain();

    // Backpressure: hold OUT for 10 cycles.
    rdy_mode = 2;
    send(2, 32'hDEAD_7777);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    check("bp_reached_out", out_valid, 1);
    repeat (10) @(negedge clk);
    check("bp_still_valid", out_valid, 1);
    check("bp_queue_pending", sbq.size(), 1);
    rdy_mode = 0;
    drain();

    // Config write and sample offered together in IDLE.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = 3'd0; cfg_data = 32'h0002_0000;
    in_valid = 1'b1; in_ch = 2'd3; in_data = 32'd1000;
    #1;
    check("contention_in_ready", in_ready, 0);
    model_cfg(3, 0, 32'h0002_0000);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check("accept_after_cfg", in_ready, 1);
    begin
      exp_t e;
      e.ch = 3;
      model_sample(3, 32'd1000, e.dat);
      e.cyc = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Writes issued while busy are dropped.
    send(2, 32'd1000);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 3'd0; cfg_data = 32'h0003_0000;
    repeat (3) @(negedge clk);
    cfg_we = 1'b0;
    drain();
    send(2, 32'd1000);
    drain();

    // Clear channel state after the first impulse sample.
    cfg_write(0, 5, 32'd0);
    send(0, 32'd65536);
    drain();
    cfg_write(0, 5, 32'hFFFF_FFFF);
    send(0, 32'd0);
    drain();

    // Reset during P2 aborts the computation.
    cfg_write(1, 1, 32'h0001_8000);
    cfg_write(1, 2, 32'h0000_4000);
    send(1, 32'd12345);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midrst");
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("midrst_no_output", out_valid, 0);
    end
    send(1, 32'd0);
    send(1, 32'd777);
    drain();

    // Randomized traffic with random backpressure and configuration.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 2)
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom);
      else
        send(int'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/iir_biquad_scheduler.md
IIR_BIQUAD_SCHEDULER -- requirements
Module: iir_biquad_scheduler

Interface
REQ-001 Parameter W, default 32: sample and coefficient width, two's complement.
REQ-002 Parameter FSW, default 16: fractional bits of all coefficients (Q(W-FSW).FSW).
REQ-003 Parameter CHB, default 2: channel-index width, giving 2^CHB channels.
REQ-004 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input sample offered.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_ch  input  CHB  channel of the offered sample.
REQ-009 in_data  input  W  signed input sample.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_ch  output  CHB  channel of the result.
REQ-013 out_data  output  W  signed filtered sample.
REQ-014 cfg_we  input  1  configuration write strobe.
REQ-015 cfg_ch  input  CHB  target channel.
REQ-016 cfg_sel  input  3  selects the target: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5=clear channel state; 6 and 7 are ignored.
REQ-017 cfg_data  input  W  coefficient value; ignored when cfg_sel=5.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Per channel, implement the transposed direct-form II biquad: y=b0*x+d0; d0'=b1*x-a1*y+d1; d1'=b2*x-a2*y.
REQ-020 Use one shared signed W x W multiplier, time-multiplexed across five product steps per sample.
REQ-021 Each product: form the full 2W-bit result, arithmetic-shift right by FSW, truncate to W bits; no rounding.
REQ-022 All sums and differences wrap modulo 2^W; no saturation.
REQ-023 Store five coefficients plus d0 and d1 for each channel in registers.
REQ-024 FSM states: IDLE, P0, P1, P2, P3, P4, OUT.
REQ-025 IDLE: in_ready=1 unless cfg_we=1; on in_valid&&in_ready, latch in_ch and in_data, then go to P0.
REQ-026 P0: y = trunc(b0*x) + d0[ch].
REQ-027 P1: acc = trunc(b1*x) + d1[ch].
REQ-028 P2: acc = acc - trunc(a1*y).
REQ-029 P3: d0[ch] <= acc; acc = trunc(b2*x).
REQ-030 P4: d1[ch] <= acc - trunc(a2*y); go to OUT.
REQ-031 OUT: out_valid=1, out_data=y, out_ch=ch; hold all three stable until out_ready=1, then return to IDLE.
REQ-032 Accept-to-out_valid latency is 6 cycles; minimum accept-to-accept interval is 7 cycles.
REQ-033 in_ready=0 in every state except IDLE.
REQ-034 Configuration writes take effect only in IDLE; cfg_we outside IDLE is dropped.
REQ-035 In IDLE, cfg_we has priority over in_valid: the write completes and no sample is accepted that cycle.
REQ-036 cfg_sel=5 zeroes d0 and d1 of cfg_ch and leaves its coefficients unchanged.
REQ-037 A computation updates state only for its own channel; all other channels are untouched.

Reset
REQ-038 On rst_n=0, asynchronously: state=IDLE; out_valid=0, out_data=0, out_ch=0, busy=0; all d0/d1=0.
REQ-039 On rst_n=0, asynchronously: b0 = 2^FSW (1.0) and b1=b2=a1=a2=0 for every channel, so every channel resets to pass-through.
REQ-040 Reset mid-computation aborts the computation, produces no output, and leaves no partial state update.
REQ-041 in_ready=1 in the first cycle after rst_n deasserts.

Verification (W=32, FSW=16, CHB=2)
REQ-042 Pass-through: after reset, send ch2 x=0x00012345 -> out_valid 6 cycles after acceptance, out_data=0x00012345, out_ch=2.
REQ-043 Impulse: ch0 b0=0x00010000, a1=0xFFFF8000, others 0; inputs 65536,0,0 -> outputs 65536, 32768, 16384.
REQ-044 Isolation: configure ch1 as REQ-043 and leave ch3 at defaults; interleave inputs ch1:65536, ch3:100, ch1:0, ch3:0 -> outputs 65536, 100, 32768, 0.
REQ-045 Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid, out_data and out_ch stable, in_ready=0 throughout; one transfer occurs when out_ready rises.
REQ-046 Contention: assert cfg_we and in_valid together in IDLE -> coefficient written, sample not accepted; the sample is accepted the following cycle.
REQ-047 Reset and clear: assert rst_n=0 during P2 -> out_valid stays 0 and d0/d1 of the channel stay 0; separately, cfg_sel=5 after REQ-043's first sample -> next input 0 yields output 0.
